// File: rtl/xrt_cell_sched.sv
// Round-robin scheduler that time-shares one external combinational xRT cell
// between two requesters, feeding one 6-bit slice per cycle and gathering o6/o5.
module xrt_cell_sched #(
  parameter int SLICES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_chain,
  input  logic [6*SLICES-1:0]   req_job0,
  input  logic [6*SLICES-1:0]   req_job1,
  output logic [1:0]            rsp_valid,
  output logic [SLICES-1:0]     rsp_result,
  output logic                  rsp_carry,
  output logic                  busy,
  output logic [5:0]            cell_i,
  input  logic                  cell_o5,
  input  logic                  cell_o6
);

  localparam int KW = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(SLICES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e               state_q;
  logic                 rr_last_q;
  logic                 owner_q;
  logic                 chain_q;
  logic [6*SLICES-1:0]  job_q;
  logic [KW-1:0]        k_q;
  logic [SLICES-1:0]    result_q;
  logic [1:0]           rsp_valid_q;
  logic [SLICES-1:0]    rsp_result_q;
  logic                 rsp_carry_q;
  logic                 busy_q;
  logic [5:0]           cell_i_q;

  logic [1:0]           grant_s;
  logic [6*SLICES-1:0]  job_sel_s;
  logic                 chain_sel_s;
  logic [6*SLICES-1:0]  job_next_s;
  logic [5:0]           slice_next_s;
  logic [SLICES-1:0]    result_d;

  // Arbitration: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    grant_s = 2'b00;
    if (state_q == ST_IDLE) begin
      case (req_valid)
        2'b01:   grant_s = 2'b01;
        2'b10:   grant_s = 2'b10;
        2'b11:   grant_s = rr_last_q ? 2'b01 : 2'b10;
        default: grant_s = 2'b00;
      endcase
    end else begin
      grant_s = 2'b00;
    end
  end

  // Winner's job/chain selection and next-slice datapath.
  always_comb begin
    job_sel_s   = grant_s[1] ? req_job1 : req_job0;
    chain_sel_s = grant_s[1] ? req_chain[1] : req_chain[0];
    // job_q shifts down one slice per RUN cycle, so the next slice sits in bits [11:6].
    job_next_s   = job_q >> 6;
    slice_next_s = job_next_s[5:0];
    if (chain_q) begin
      slice_next_s[5] = cell_o5;
    end else begin
      slice_next_s[5] = job_next_s[5];
    end
    result_d       = result_q;
    result_d[k_q]  = cell_o6;
  end

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rr_last_q    <= 1'b1;
      owner_q      <= 1'b0;
      chain_q      <= 1'b0;
      job_q        <= '0;
      k_q          <= '0;
      result_q     <= '0;
      rsp_valid_q  <= 2'b00;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      busy_q       <= 1'b0;
      cell_i_q     <= 6'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          rsp_valid_q <= 2'b00;
          if (grant_s != 2'b00) begin
            job_q     <= job_sel_s;
            chain_q   <= chain_sel_s;
            owner_q   <= grant_s[1];
            rr_last_q <= grant_s[1];
            k_q       <= '0;
            cell_i_q  <= job_sel_s[5:0];
            busy_q    <= 1'b1;
            state_q   <= ST_RUN;
          end else begin
            cell_i_q  <= 6'd0;
            busy_q    <= 1'b0;
          end
        end
        ST_RUN: begin
          result_q <= result_d;
          job_q    <= job_next_s;
          if (k_q == K_LAST) begin
            k_q          <= '0;
            rsp_result_q <= result_d;
            rsp_carry_q  <= cell_o5;
            rsp_valid_q  <= owner_q ? 2'b10 : 2'b01;
            cell_i_q     <= 6'd0;
            state_q      <= ST_DONE;
          end else begin
            k_q      <= k_q + KW'(1);
            cell_i_q <= slice_next_s;
          end
        end
        ST_DONE: begin
          rsp_valid_q <= 2'b00;
          busy_q      <= 1'b0;
          cell_i_q    <= 6'd0;
          state_q     <= ST_IDLE;
        end
        default: begin
          rsp_valid_q <= 2'b00;
          busy_q      <= 1'b0;
          cell_i_q    <= 6'd0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = grant_s;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_carry  = rsp_carry_q;
  assign busy       = busy_q;
  assign cell_i     = cell_i_q;

endmodule

// File: tb/tb_xrt_cell_sched.sv
// Scoreboard bench for xrt_cell_sched: a behavioural cell and job model predicts
// grants, per-cycle cell drive and responses; a monitor checks them.
module tb_xrt_cell_sched;
  localparam int S = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [1:0]     req_valid, req_ready, req_chain, rsp_valid;
  logic [6*S-1:0] req_job0, req_job1;
  logic [S-1:0]   rsp_result;
  logic           rsp_carry, busy, cell_o5, cell_o6;
  logic [5:0]     cell_i;

  logic [1:0]     d1_valid, d1_ready, d1_chain, d1_rsp_valid;
  logic [5:0]     d1_job0, d1_job1, d1_cell_i;
  logic [0:0]     d1_result;
  logic           d1_carry, d1_busy, d1_o5, d1_o6;

  function automatic logic o5f(input logic [5:0] i);
    return (!i[4] & !i[3] & i[2] & i[1]) | (!i[4] & i[3] & !i[2] & i[1]) |
           (i[3] & i[2] & i[0]) | (i[4] & !i[3] & !i[2] & !i[0]) |
           (!i[4] & !i[2] & !i[0]) | (i[4] & i[3] & i[2]);
  endfunction

  assign cell_o5 = o5f(cell_i);
  assign cell_o6 = cell_i[5] ^ cell_o5;
  assign d1_o5   = o5f(d1_cell_i);
  assign d1_o6   = d1_cell_i[5] ^ d1_o5;

  xrt_cell_sched #(.SLICES(S)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_chain(req_chain), .req_job0(req_job0), .req_job1(req_job1),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_carry(rsp_carry),
    .busy(busy), .cell_i(cell_i), .cell_o5(cell_o5), .cell_o6(cell_o6));

  xrt_cell_sched #(.SLICES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(d1_valid), .req_ready(d1_ready),
    .req_chain(d1_chain), .req_job0(d1_job0), .req_job1(d1_job1),
    .rsp_valid(d1_rsp_valid), .rsp_result(d1_result), .rsp_carry(d1_carry),
    .busy(d1_busy), .cell_i(d1_cell_i), .cell_o5(d1_o5), .cell_o6(d1_o6));

  typedef struct {
    int           due;
    logic         owner;
    logic [S-1:0] res;
    logic         carry;
  } exp_t;

  exp_t           sbq[$];
  int             total = 0;
  int             bad = 0;
  int             e = 0;
  int             cur_acc = -100;
  logic [6*S-1:0] cur_vec = '0;
  logic           rr_m = 1'b1;
  bit             mon_en = 1'b0;
  bit             ov_en = 1'b0;
  logic [S-1:0]   ov_res[2];
  logic           ov_carry[2];

  logic           m_bexp;
  logic [5:0]     m_cexp;
  exp_t           m_x;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, e);
    end
  endtask

  function automatic logic [6*S-1:0] rep(input logic [5:0] s);
    return {S{s}};
  endfunction

  function automatic bit model_busy();
    return (cur_acc <= e) && (e <= cur_acc + S);
  endfunction

  // Job semantics: slice by slice through the cell, chaining o5 into i5 if asked.
  task automatic ref_job(input logic [6*S-1:0] job, input logic ch,
                         output logic [6*S-1:0] vv, output logic [S-1:0] r, output logic c);
    logic       prev;
    logic [5:0] v;
    prev = 1'b0;
    vv = '0;
    r = '0;
    for (int k = 0; k < S; k++) begin
      v = job[6*k +: 6];
      if (ch && k > 0) v[5] = prev;
      prev = o5f(v);
      r[k] = v[5] ^ prev;
      vv[6*k +: 6] = v;
    end
    c = prev;
  endtask

  always @(posedge clk) e <= e + 1;

  // Monitor: per-cycle busy/cell drive check and scoreboard pop on responses.
  always @(negedge clk) begin
    if (mon_en) begin
      m_bexp = model_busy();
      m_cexp = 6'd0;
      if (cur_acc <= e && e < cur_acc + S) m_cexp = cur_vec[6*(e-cur_acc) +: 6];
      chk("busy", {63'd0, busy}, {63'd0, m_bexp});
      chk("cell_i", {58'd0, cell_i}, {58'd0, m_cexp});
      if (sbq.size() > 0 && sbq[0].due <= e) begin
        m_x = sbq.pop_front();
        chk("rsp_valid", {62'd0, rsp_valid}, m_x.owner ? 64'd2 : 64'd1);
        chk("rsp_result", {56'd0, rsp_result}, {56'd0, m_x.res});
        chk("rsp_carry", {63'd0, rsp_carry}, {63'd0, m_x.carry});
        chk("rsp_time", 64'(e), 64'(m_x.due));
      end else begin
        chk("rsp_idle", {62'd0, rsp_valid}, 64'd0);
      end
    end
  end

  task automatic step(input logic [1:0] v, input logic [1:0] ch,
                      input logic [6*S-1:0] j0, input logic [6*S-1:0] j1, input logic rs);
    logic [1:0]     g;
    logic           o;
    logic [6*S-1:0] vv;
    logic [S-1:0]   r;
    logic           c;
    exp_t           x;
    @(negedge clk);
    #1;
    rst_n = rs; req_valid = v; req_chain = ch; req_job0 = j0; req_job1 = j1;
    #1;
    if (!rs) begin
      sbq.delete();
      cur_acc = -100;
      rr_m = 1'b1;
    end else begin
      g = 2'b00;
      if (!model_busy()) begin
        if (v == 2'b01) g = 2'b01;
        else if (v == 2'b10) g = 2'b10;
        else if (v == 2'b11) g = rr_m ? 2'b01 : 2'b10;
      end
      chk("req_ready", {62'd0, req_ready}, {62'd0, g});
      if (g != 2'b00) begin
        o = g[1];
        ref_job(o ? j1 : j0, ch[o], vv, r, c);
        if (ov_en) begin
          r = ov_res[o];
          c = ov_carry[o];
        end
        x.due = e + 1 + S; x.owner = o; x.res = r; x.carry = c;
        sbq.push_back(x);
        cur_acc = e + 1;
        cur_vec = vv;
        rr_m = o;
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && (sbq.size() != 0 || model_busy()); i++)
      step(2'b00, 2'b00, '0, '0, 1'b1);
    if (sbq.size() != 0 || model_busy()) begin
      total++; bad++;
      $display("FAIL idle_timeout: pending=%0d required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic run_job(input logic r, input logic [6*S-1:0] job, input logic ch,
                         input logic [S-1:0] er, input logic ec);
    ov_en = 1'b1; ov_res[r] = er; ov_carry[r] = ec;
    step(r ? 2'b10 : 2'b01, {ch, ch}, job, job, 1'b1);
    wait_idle();
    ov_en = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] t0, t1;
    rst_n = 1'b0; req_valid = 2'b00; req_chain = 2'b00; req_job0 = '0; req_job1 = '0;
    d1_valid = 2'b00; d1_chain = 2'b00; d1_job0 = 6'd0; d1_job1 = 6'd0;
    ov_res[0] = '0; ov_res[1] = '0; ov_carry[0] = 1'b0; ov_carry[1] = 1'b0;
    step(2'b00, 2'b00, '0, '0, 1'b0);
    step(2'b00, 2'b00, '0, '0, 1'b0);
    mon_en = 1'b1;
    @(negedge clk);
    chk("reset_result", {56'd0, rsp_result}, 64'd0);
    chk("reset_carry", {63'd0, rsp_carry}, 64'd0);

    // Contention from the first cycle: R0, R1, then R0 again.
    ov_en = 1'b1;
    ov_res[0] = 8'hFF; ov_carry[0] = 1'b1;
    ov_res[1] = 8'h00; ov_carry[1] = 1'b1;
    for (int i = 0; i < 30; i++) step(2'b11, 2'b00, rep(6'b000000), rep(6'b111111), 1'b1);
    wait_idle();
    ov_en = 1'b0;

    run_job(1'b0, rep(6'b011111), 1'b1, 8'h01, 1'b1);
    run_job(1'b0, rep(6'b011111), 1'b0, 8'hFF, 1'b1);
    run_job(1'b1, rep(6'b111111), 1'b0, 8'h00, 1'b1);
    run_job(1'b0, rep(6'b000000), 1'b0, 8'hFF, 1'b1);

    // Abort an R0 job during slice 4; afterwards R0 must win contention again.
    step(2'b01, 2'b00, rep(6'b101010), '0, 1'b1);
    for (int i = 0; i < 4; i++) step(2'b00, 2'b00, '0, '0, 1'b1);
    step(2'b00, 2'b00, '0, '0, 1'b0);
    step(2'b11, 2'b11, rep(6'b010101), rep(6'b110011), 1'b1);
    wait_idle();

    for (int i = 0; i < 500; i++) begin
      t0 = {$urandom(), $urandom()};
      t1 = {$urandom(), $urandom()};
      step(2'($urandom()), 2'($urandom()), t0[6*S-1:0], t1[6*S-1:0],
           ($urandom_range(0, 79) != 0));
    end
    wait_idle();

    // Single-slice instance: chain has no effect on slice 0.
    @(negedge clk); #1;
    d1_valid = 2'b10; d1_chain = 2'b10; d1_job1 = 6'b100000; d1_job0 = 6'b011111;
    #1;
    chk("d1_ready", {62'd0, d1_ready}, 64'd2);
    @(negedge clk); #1;
    d1_valid = 2'b00;
    chk("d1_cell_i", {58'd0, d1_cell_i}, 64'h20);
    chk("d1_busy", {63'd0, d1_busy}, 64'd1);
    @(negedge clk);
    chk("d1_rsp_valid", {62'd0, d1_rsp_valid}, 64'd2);
    chk("d1_result", {63'd0, d1_result}, 64'd0);
    chk("d1_carry", {63'd0, d1_carry}, 64'd1);
    @(negedge clk);
    chk("d1_rsp_drop", {62'd0, d1_rsp_valid}, 64'd0);
    chk("d1_carry_hold", {63'd0, d1_carry}, 64'd1);
    chk("d1_idle_cell", {58'd0, d1_cell_i}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xrt_cell_sched.md
Name: xrt_cell_sched

Overview:
- Time-shares one external combinational xRT approximate cell between two requesters.
- Cell function, for cell input {i5,i4,i3,i2,i1,i0}:
  - o5 = i4'i3'i2i1 | i4'i3i2'i1 | i3i2i0 | i4i3'i2'i0' | i4'i2'i0' | i4i3i2
  - o6 = i5 ^ o5
- A job is SLICES 6-bit cell vectors. The block arbitrates round-robin, feeds one slice per cycle, collects o6 bits into a result word and returns the last slice's o5 as carry.
- Chain mode drives i5 of each slice from the previous slice's o5, forming a serial approximate ripple adder.

Parameters:
- SLICES, 8, slices per job; legal 1..32. Slice counter width is clog2(SLICES), minimum 1.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  2  per-requester job request
- req_ready  out  2  per-requester accept; combinational, at most one bit high
- req_chain  in  2  per-requester chain-mode select, sampled at accept
- req_job0  in  6*SLICES  requester 0 job; slice k = bits [6k+5:6k]
- req_job1  in  6*SLICES  requester 1 job, same packing
- rsp_valid  out  2  one-cycle completion pulse to the owning requester
- rsp_result  out  SLICES  bit k = o6 of slice k; valid while rsp_valid is high
- rsp_carry  out  1  o5 of slice SLICES-1; valid while rsp_valid is high
- busy  out  1  high in RUN and DONE
- cell_i  out  6  drive to the cell, {i5..i0}
- cell_o5  in  1  cell o5
- cell_o6  in  1  cell o6

Behaviour:
- Reset, sampled at a clk edge with rst_n=0:
  - State goes to IDLE; rr_last goes to 1, so requester 0 wins first.
  - Job, result, carry and slice counter registers clear.
  - rsp_valid=0, rsp_result=0, rsp_carry=0, busy=0, cell_i=0.
  - A job in progress is aborted silently and produces no rsp_valid.
- FSM:
  - IDLE: cell_i=0.
    - req_ready: if exactly one req_valid bit is set, that requester gets ready. If both are set, the requester != rr_last gets ready.
    - On handshake (valid & ready), at the same edge: latch the job and chain bit, record owner, set rr_last=owner, clear slice k=0, go to RUN.
    - req_ready is 0 in every other state.
  - RUN, slice k:
    - cell_i = job[6k+5:6k], except i5 = prev_o5 when chain=1 and k>0. Slice 0 always uses its own job bit.
    - At the clock edge: result[k] <= cell_o6; prev_o5 <= cell_o5; k <= k+1.
    - At k=SLICES-1: carry <= cell_o5, go to DONE.
  - DONE:
    - rsp_valid[owner]=1 for exactly one cycle, with registered rsp_result and rsp_carry.
    - Go to IDLE; no accept in DONE.
- Timing:
  - Accept at edge T: slice k is driven in cycle T+1+k; rsp_valid is high in cycle T+SLICES+1.
  - Next accept is possible at edge T+SLICES+2 at the earliest. Throughput is 1 job per SLICES+2 cycles.
- Requester inputs need not stay stable after accept; they are ignored outside IDLE.
- rsp_result and rsp_carry hold their last values after rsp_valid drops.
- Cell is combinational: cell_i is stable all cycle and is a function of registered state only. cell_o5 and cell_o6 are sampled at the same-cycle edge.
- SLICES=1: RUN lasts one cycle; chain has no effect.

Test Plan:
- SLICES=8, R0 job all slices 6'b000000, chain=0, accepted at cycle 0 -> rsp_valid[0] in cycle 9, rsp_result=8'hFF, rsp_carry=1, rsp_valid[1]=0.
- R1 job all slices 6'b111111, chain=0 -> rsp_valid[1], rsp_result=8'h00, rsp_carry=1.
- R0 job all slices 6'b011111, chain=1 -> rsp_result=8'h01 (slice 0 uses its own i5=0; later slices get i5=1, giving o6=0), rsp_carry=1. Same job with chain=0 -> rsp_result=8'hFF.
- Both req_valid high from cycle 0 after reset:
  - R0 accepted cycle 0, rsp_valid[0] at cycle 9.
  - R1 accepted cycle 10, rsp_valid[1] at cycle 19.
  - Then both re-assert: R0 wins again (rr_last=1).
  - Never both req_ready bits high; req_ready=0 while busy.
- rst_n=0 for one cycle during RUN slice 4 -> next cycle IDLE, busy=0, cell_i=0, no rsp_valid ever for that job. Next request is granted to R0.
- SLICES=1, R1 job 6'b100000, chain=1 -> cell_i=6'b100000 in cycle 1, rsp_result=1'b0, rsp_carry=1 in cycle 2.
